// File: rtl/instr_cache_dm_pkg.sv
// Shared encodings, default geometry and width helpers for the direct-mapped I-cache.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package instr_cache_dm_pkg;

  // FSM encoding: IDLE serves lookups, REFILL streams one line in from memory
  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_t;

  localparam int IC_DEF_LINES          = 16;
  localparam int IC_DEF_WORDS_PER_LINE = 32;
  localparam int IC_ADDR_W             = 30;
  localparam int IC_DATA_W             = 32;

  // Tag width left over from the 30-bit word address once index and offset are taken
  function automatic int ic_tag_w(input int lines, input int words);
    return IC_ADDR_W - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/instr_cache_dm_line.sv
// One cache line: word storage, tag and valid bit, with a single refill write port.
// Latency: read is combinational on rd_off; writes/valid changes land on the next edge.
// Backpressure: none; clear takes priority over set_valid.
module instr_cache_line
  import instr_cache_dm_pkg::*;
#(
  parameter int WORDS = IC_DEF_WORDS_PER_LINE,
  parameter int OFF_W = 5,
  parameter int TAG_W = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 we,
  input  logic [OFF_W-1:0]     wsel,
  input  logic [IC_DATA_W-1:0] wdata,
  input  logic                 set_valid,
  input  logic [TAG_W-1:0]     set_tag,
  input  logic [OFF_W-1:0]     rd_off,
  output logic [IC_DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]     tag,
  output logic                 valid
);

  logic [IC_DATA_W-1:0] data_q [WORDS];

  // Refill beats write one word; data is only trusted once valid is set, so no reset
  always_ff @(posedge clk) begin
    if (we) data_q[wsel] <= wdata;
  end

  // Tag is captured together with the valid bit when the last beat commits the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag <= '0;
    else if (set_valid) tag <= set_tag;
  end

  // Valid bit: flush/refill-entry clear wins over commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (set_valid) valid <= 1'b1;
  end

  assign rd_data = data_q[rd_off];

endmodule

// File: rtl/instr_cache_dm.sv
// Direct-mapped read-only instruction cache; optional hit/miss counters under ICACHE_STATS_EN.
// Latency: hit returns data combinationally; miss costs WORDS_PER_LINE beats + 1 cycle.
// Backpressure: stall_o holds fetch during a miss; mem_req_o/mem_address_o hold until mem_valid_i.
module instr_cache_dm
  import instr_cache_dm_pkg::*;
#(
  parameter int LINES          = IC_DEF_LINES,
  parameter int WORDS_PER_LINE = IC_DEF_WORDS_PER_LINE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [IC_ADDR_W-1:0] address_i,
  output logic [IC_DATA_W-1:0] read_data_o,
  output logic                 hit_o,
  output logic                 stall_o,
  input  logic                 flush_i,
  output logic                 mem_req_o,
  output logic [IC_ADDR_W-1:0] mem_address_o,
  input  logic [IC_DATA_W-1:0] mem_data_i,
  input  logic                 mem_valid_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int TAG_W   = ic_tag_w(LINES, WORDS_PER_LINE);

  ic_state_t            state_q, state_d;
  logic [OFF_W-1:0]     cnt_q;
  logic [TAG_W-1:0]     miss_tag_q;
  logic [INDEX_W-1:0]   miss_idx_q;
  logic                 flush_pending_q;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [OFF_W-1:0]     req_off;

  logic [IC_DATA_W-1:0] line_rd_data [LINES];
  logic [TAG_W-1:0]     line_tag     [LINES];
  logic [LINES-1:0]     line_valid;

  logic                 start_refill;
  logic                 beat;
  logic                 last_beat;
  logic                 commit;

  assign req_tag = address_i[IC_ADDR_W-1 -: TAG_W];
  assign req_idx = address_i[OFF_W +: INDEX_W];
  assign req_off = address_i[OFF_W-1:0];

  // Lookup is only honoured in IDLE: no hit-under-miss
  assign hit_o       = req_valid_i & line_valid[req_idx] & (line_tag[req_idx] == req_tag)
                     & (state_q == IC_IDLE);
  assign stall_o     = req_valid_i & ~hit_o;
  assign read_data_o = line_rd_data[req_idx];

  // A flush in the same cycle as a miss suppresses the refill; fetch retries next cycle
  assign start_refill = (state_q == IC_IDLE) & req_valid_i & ~hit_o & ~flush_i;
  assign beat         = (state_q == IC_REFILL) & mem_valid_i;
  assign last_beat    = beat & (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
  // A flush seen at any point of the refill keeps the line invalid at the end
  assign commit       = last_beat & ~flush_pending_q & ~flush_i;

  // Next-state and memory-side outputs; the address bus is parked at zero outside REFILL
  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    mem_address_o = '0;
    case (state_q)
      IC_IDLE: begin
        if (start_refill) state_d = IC_REFILL;
      end
      IC_REFILL: begin
        mem_req_o     = 1'b1;
        mem_address_o = {miss_tag_q, miss_idx_q, cnt_q};
        if (last_beat) state_d = IC_IDLE;
      end
    endcase
  end

  // State register; async reset drops mem_req_o immediately and abandons a refill
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IC_IDLE;
    else state_q <= state_d;
  end

  // Beat counter advances per accepted beat and wraps to 0 after the last one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (beat) cnt_q <= cnt_q + 1'b1;
  end

  // Capture the missing line's tag/index at refill start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else if (start_refill) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
    end
  end

  // Remember a flush that arrives while a refill is draining
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) flush_pending_q <= 1'b0;
    else if (last_beat) flush_pending_q <= 1'b0;
    else if (flush_i && state_q == IC_REFILL) flush_pending_q <= 1'b1;
  end

  for (genvar g = 0; g < LINES; g++) begin : g_line
    instr_cache_line #(
      .WORDS (WORDS_PER_LINE),
      .OFF_W (OFF_W),
      .TAG_W (TAG_W)
    ) u_line (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (flush_i | (start_refill & (req_idx == INDEX_W'(g)))),
      .we        (beat & (miss_idx_q == INDEX_W'(g))),
      .wsel      (cnt_q),
      .wdata     (mem_data_i),
      .set_valid (commit & (miss_idx_q == INDEX_W'(g))),
      .set_tag   (miss_tag_q),
      .rd_off    (req_off),
      .rd_data   (line_rd_data[g]),
      .tag       (line_tag[g]),
      .valid     (line_valid[g])
    );
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit counter: one count per IDLE cycle with a served request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hit_cnt_o <= '0;
    else if (hit_o && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
  end

  // Saturating miss counter: one count per refill started
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) miss_cnt_o <= '0;
    else if (start_refill && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_cache_dm.sv
// Directed bench for instr_cache_dm with a behavioural memory responder.
// Latency: checks the 33-cycle miss penalty with a zero-wait memory.
// Backpressure: responder inserts random wait states and checks address hold.
module tb_instr_cache_dm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic [29:0] address_i;
  logic [31:0] read_data_o;
  logic        hit_o;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [29:0] mem_address_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_valid_i = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  int max_wait = 0;
  logic [29:0] beat_q [$];

  instr_cache_dm dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .address_i     (address_i),
    .read_data_o   (read_data_o),
    .hit_o         (hit_o),
    .stall_o       (stall_o),
    .flush_i       (flush_i),
    .mem_req_o     (mem_req_o),
    .mem_address_o (mem_address_o),
    .mem_data_i    (mem_data_i),
    .mem_valid_i   (mem_valid_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Memory content is a fixed hash of the word address
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: beats driven on the falling edge, optional wait states per beat
  bit          in_beat = 1'b0;
  logic [29:0] cur_addr = '0;
  int          wait_left = 0;
  always @(negedge clk_i) begin
    if (mem_req_o) begin
      if (!in_beat) begin
        in_beat   = 1'b1;
        cur_addr  = mem_address_o;
        wait_left = (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
      end else begin
        check("addr_hold", {2'b00, mem_address_o}, {2'b00, cur_addr});
      end
      if (wait_left == 0) begin
        mem_valid_i = 1'b1;
        mem_data_i  = mem_word(mem_address_o);
        beat_q.push_back(mem_address_o);
        in_beat     = 1'b0;
      end else begin
        mem_valid_i = 1'b0;
        wait_left--;
      end
    end else begin
      mem_valid_i = 1'b0;
      in_beat     = 1'b0;
    end
  end

  // One fetch: check hit/stall; on a miss wait for the refill, then check beats and data
  task automatic access(input logic [29:0] a, input bit exp_hit, input string name);
    int n;
    @(negedge clk_i);
    beat_q.delete();
    address_i   = a;
    req_valid_i = 1'b1;
    #1;
    check({name, "_hit"}, 32'(hit_o), 32'(exp_hit));
    check({name, "_stall"}, 32'(stall_o), 32'(!exp_hit));
    if (!exp_hit) begin
      n = 0;
      while (!hit_o && n < 2000) begin
        @(negedge clk_i);
        #1;
        n++;
      end
      check({name, "_refill_hit"}, 32'(hit_o), 32'd1);
      check({name, "_beats"}, beat_q.size(), 32);
      if (max_wait == 0) check({name, "_penalty"}, n, 33);
      if (beat_q.size() == 32)
        for (int i = 0; i < 32; i++)
          check({name, "_beat_addr"}, {2'b00, beat_q[i]}, {2'b00, a[29:5], 5'(i)});
    end
    check({name, "_data"}, read_data_o, mem_word(a));
  endtask

  // Hold flush_i while probing so a miss cannot launch a refill
  task automatic probe_miss(input logic [29:0] a, input string name);
    @(negedge clk_i);
    address_i   = a;
    req_valid_i = 1'b1;
    flush_i     = 1'b1;
    #1;
    check({name, "_hit"}, 32'(hit_o), 32'd0);
    check({name, "_stall"}, 32'(stall_o), 32'd1);
    check({name, "_no_req"}, 32'(mem_req_o), 32'd0);
  endtask

  typedef struct {
    logic [29:0] addr;
    bit          hit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    // Word addresses (byte address >> 2): 0x40->0x10, 0x800->0x200, 0x780->0x1E0
    vecs[0]  = '{30'h0000_0010, 1'b0};  // first miss, line index 0
    vecs[1]  = '{30'h0000_0000, 1'b1};  // offset 0 of same line
    vecs[2]  = '{30'h0000_001F, 1'b1};  // offset wrap boundary
    vecs[3]  = '{30'h0000_01E0, 1'b0};  // index 15
    vecs[4]  = '{30'h0000_01FF, 1'b1};
    vecs[5]  = '{30'h0000_0200, 1'b0};  // B evicts A at index 0
    vecs[6]  = '{30'h0000_0000, 1'b0};  // A misses again
    vecs[7]  = '{30'h0000_01E5, 1'b1};  // index 15 untouched
    vecs[8]  = '{30'h0000_0200, 1'b0};
    vecs[9]  = '{30'h3FFF_FFFF, 1'b0};  // all-ones tag, index 15, last offset
    vecs[10] = '{30'h3FFF_FFE0, 1'b1};
    vecs[11] = '{30'h0000_01E0, 1'b0};  // evicted by all-ones tag

    rst_i = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; address_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", {2'b00, mem_address_o}, 32'd0);
    check("rst_hit", 32'(hit_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    req_valid_i = 1'b1; address_i = 30'h10;
    #1;
    check("rst_req_hit", 32'(hit_o), 32'd0);
    check("rst_req_stall", 32'(stall_o), 32'd1);
    req_valid_i = 1'b0;
`ifdef ICACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven lookups with zero-wait memory
    for (int i = 0; i < 12; i++) access(vecs[i].addr, vecs[i].hit, $sformatf("vec%0d", i));

    // Whole line streamed back-to-back: all hits, no stalls
    for (int i = 0; i < 32; i++) access({25'h10, 5'(i)}, 1'b1, "s2");

    // Memory with 0-3 wait cycles per beat
    max_wait = 3;
    access(30'h40, 1'b0, "s4_miss");
    for (int i = 0; i < 32; i++) access({25'h2, 5'(i)}, 1'b1, "s4");
    max_wait = 0;

    // Flush in IDLE: same-cycle request still hits, everything misses afterwards
    @(negedge clk_i);
    address_i = 30'h200; req_valid_i = 1'b1; flush_i = 1'b1;
    #1;
    check("fl_same_cycle_hit", 32'(hit_o), 32'd1);
    check("fl_same_cycle_data", read_data_o, mem_word(30'h200));
    probe_miss(30'h1E0, "fl_idx15");
    probe_miss(30'h40, "fl_idx2");
    probe_miss(30'h200, "fl_idx0");
    flush_i = 1'b0; req_valid_i = 1'b0;

    // Flush during a refill: all 32 beats still run, line stays invalid
    @(negedge clk_i);
    beat_q.delete();
    address_i = 30'h60; req_valid_i = 1'b1;
    n = 0;
    while (beat_q.size() < 10 && n < 200) begin @(negedge clk_i); #1; n++; end
    check("s5_reach_beat10", beat_q.size(), 10);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    n = 0;
    while (mem_req_o && n < 200) begin @(negedge clk_i); #1; n++; end
    check("s5_beats", beat_q.size(), 32);
    check("s5_after_hit", 32'(hit_o), 32'd0);
    check("s5_after_stall", 32'(stall_o), 32'd1);
    n = 0;
    while (!hit_o && n < 200) begin @(negedge clk_i); #1; n++; end
    check("s5_rehit", 32'(hit_o), 32'd1);
    check("s5_rehit_data", read_data_o, mem_word(30'h60));

    // Reset during a refill
    @(negedge clk_i);
    beat_q.delete();
    address_i = 30'h80; req_valid_i = 1'b1;
    n = 0;
    while (beat_q.size() < 5 && n < 200) begin @(negedge clk_i); #1; n++; end
    check("s6_reach_beat5", beat_q.size(), 5);
    rst_i = 1'b1;
    #1;
    check("s6_req_drop", 32'(mem_req_o), 32'd0);
    check("s6_addr_zero", {2'b00, mem_address_o}, 32'd0);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
`ifdef ICACHE_STATS_EN
    check("s6_hit_cnt_rst", hit_cnt_o, 32'd0);
    check("s6_miss_cnt_rst", miss_cnt_o, 32'd0);
`endif
    probe_miss(30'h80, "s6_idx4");
    probe_miss(30'h60, "s6_idx3");
    probe_miss(30'h1E0, "s6_idx15");
    probe_miss(30'h10, "s6_idx0");
    flush_i = 1'b0; req_valid_i = 1'b0;

    // One miss then 32 hit cycles in total on that line
    access(30'h10, 1'b0, "st_miss");
    for (int i = 0; i < 32; i++)
      if (i != 16) access({25'h0, 5'(i)}, 1'b1, "st");
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
`ifdef ICACHE_STATS_EN
    check("st_hit_cnt", hit_cnt_o, 32'd32);
    check("st_miss_cnt", miss_cnt_o, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
